// File: rtl/serial_word_rx_pkg.sv
// Shared definitions for the serial shift-register link (receiver and transmitter).
// Contents: FSM state encoding and the bit-order constants carried on DIR.
// Latency/backpressure: n/a (types and constants only).
package serial_link_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // DIR encoding; the transmitter uses the same values.
  localparam logic DIR_MSB_FIRST = 1'b0;  // sender shifts left
  localparam logic DIR_LSB_FIRST = 1'b1;  // sender shifts right

endpackage

// File: rtl/serial_word_rx_if.sv
// Bundle of the serial input, the parallel output handshake and status for serial_word_rx.
// master: the side that drives EN/SOF/DIR/SDI/READY/CLR_OVR and observes Q/VALID/BUSY/OVR.
// slave : the receiver itself (drives Q/VALID/BUSY/OVR).
interface serial_word_rx_if #(
  parameter int WIDTH = 4
);
  logic             EN;       // bit strobe
  logic             SOF;      // start of frame, qualified by EN
  logic             DIR;      // bit order, sampled with SOF
  logic             SDI;      // serial data
  logic             READY;    // consumer accepts Q
  logic             CLR_OVR;  // synchronous clear of OVR
  logic [WIDTH-1:0] Q;        // last completed word
  logic             VALID;    // Q holds an unconsumed word
  logic             BUSY;     // frame in progress
  logic             OVR;      // sticky overrun

  modport master (
    output EN, SOF, DIR, SDI, READY, CLR_OVR,
    input  Q, VALID, BUSY, OVR
  );

  modport slave (
    input  EN, SOF, DIR, SDI, READY, CLR_OVR,
    output Q, VALID, BUSY, OVR
  );
endinterface

// File: rtl/serial_word_rx_sipo_shift_stage.sv
// WIDTH-bit assembly register: loads the first bit of a frame or shifts in the next bit.
// Ports: i_clk/i_rst_n, i_en (advance), i_load_first (start new frame), i_dir, i_sdi,
//        o_asm_nxt = value the register takes on the next enabled edge (combinational).
module sipo_shift_stage
  import serial_link_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load_first,
  input  logic             i_dir,
  input  logic             i_sdi,
  output logic [WIDTH-1:0] o_asm_nxt
);

  logic [WIDTH-1:0] r_asm;
  logic [WIDTH-1:0] w_asm_nxt;

  // Loading the first bit clears the stale partial frame so a restarted
  // frame never carries bits from the abandoned one.
  always_comb begin
    w_asm_nxt = r_asm;
    if (i_load_first) begin
      if (i_dir == DIR_MSB_FIRST) w_asm_nxt = {{(WIDTH-1){1'b0}}, i_sdi};
      else                        w_asm_nxt = {i_sdi, {(WIDTH-1){1'b0}}};
    end else begin
      if (i_dir == DIR_MSB_FIRST) w_asm_nxt = {r_asm[WIDTH-2:0], i_sdi};
      else                        w_asm_nxt = {i_sdi, r_asm[WIDTH-1:1]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_asm <= '0;
    else if (i_en) r_asm <= w_asm_nxt;
  end

  assign o_asm_nxt = w_asm_nxt;

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel frame receiver with a one-entry output buffer and sticky overrun flag.
// Ports: CP clock, CR async active-low clear, bus (slave modport) carrying serial in,
//        Q/VALID/READY handshake and BUSY/OVR status. Q/VALID update on the final-bit edge.
module serial_word_rx
  import serial_link_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic            CP,
  input  logic            CR,
  serial_word_rx_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_ovr;

  logic             w_start;
  logic             w_shift_bit;
  logic             w_done;
  logic             w_stage_en;
  logic             w_dir;
  logic [WIDTH-1:0] w_word;

  // SOF wins over an in-progress frame: the partial word is abandoned.
  assign w_start     = bus.EN && bus.SOF;
  assign w_shift_bit = bus.EN && !bus.SOF && (r_state == RECV);
  assign w_done      = w_shift_bit && (r_cnt == CNT_LAST);
  assign w_stage_en  = w_start || w_shift_bit;
  // DIR is only honoured on the SOF bit; later bits use the latched order.
  assign w_dir       = bus.SOF ? bus.DIR : r_dir;

  sipo_shift_stage #(.WIDTH(WIDTH)) u_stage (
    .i_clk        (CP),
    .i_rst_n      (CR),
    .i_en         (w_stage_en),
    .i_load_first (w_start),
    .i_dir        (w_dir),
    .i_sdi        (bus.SDI),
    .o_asm_nxt    (w_word)
  );

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= DIR_MSB_FIRST;
      r_q     <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      // Frame sequencing; cnt stays at WIDTH after completion until the next SOF.
      if (w_start) begin
        r_state <= RECV;
        r_cnt   <= CNT_ONE;
        r_dir   <= bus.DIR;
      end else if (w_shift_bit) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_done) r_state <= IDLE;
      end

      // Output buffer: a completing word may replace one being consumed this cycle.
      if (w_done) begin
        if (!r_valid || bus.READY) begin
          r_q     <= w_word;
          r_valid <= 1'b1;
        end
      end else if (r_valid && bus.READY) begin
        r_valid <= 1'b0;
      end

      // Overrun set beats clear in the same cycle.
      if (w_done && r_valid && !bus.READY) r_ovr <= 1'b1;
      else if (bus.CLR_OVR)                r_ovr <= 1'b0;
    end
  end

  assign bus.Q     = r_q;
  assign bus.VALID = r_valid;
  assign bus.BUSY  = (r_state == RECV);
  assign bus.OVR   = r_ovr;

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: directed scenarios plus random traffic against a frame-level model.
// Expected words go into a queue when the model completes them; a monitor pops on each load.
// Inputs change 1 time unit after the falling edge; the monitor samples on the falling edge.
module tb_serial_word_rx;
  import serial_link_pkg::*;

  localparam int W = 4;

  logic CP = 1'b0;
  logic CR;
  always #5 CP = ~CP;

  serial_word_rx_if #(.WIDTH(W)) bus ();

  serial_word_rx #(.WIDTH(W)) dut (
    .CP  (CP),
    .CR  (CR),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: frame-level view (list of received bits).
  logic [W-1:0] sb[$];
  bit           m_active;
  bit           m_dir;
  bit           m_valid;
  bit           m_ovr;
  bit           m_bits[$];
  logic [W-1:0] m_q;
  bit           mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_dir = 0; m_valid = 0; m_ovr = 0; m_q = '0;
    m_bits.delete();
  endtask

  // One clock of stimulus; model advanced to the state after the coming rising edge.
  task automatic step(input bit en, input bit sof, input bit dir, input bit sdi,
                      input bit ready, input bit clr);
    logic [W-1:0] word;
    bit done;
    bit lost;
    @(negedge CP);
    #1;
    bus.EN = en; bus.SOF = sof; bus.DIR = dir; bus.SDI = sdi;
    bus.READY = ready; bus.CLR_OVR = clr;
    done = 0; lost = 0; word = '0;
    if (en) begin
      if (sof) begin
        m_active = 1; m_dir = dir;
        m_bits.delete();
        m_bits.push_back(sdi);
      end else if (m_active) begin
        m_bits.push_back(sdi);
        if (m_bits.size() == W) begin
          done = 1; m_active = 0;
          // Bit k of the frame: MSB-first puts it at weight W-1-k, LSB-first at weight k.
          for (int k = 0; k < W; k++) begin
            if (m_dir == DIR_MSB_FIRST) word[W-1-k] = m_bits[k];
            else                        word[k]     = m_bits[k];
          end
        end
      end
    end
    if (done) begin
      if (!m_valid || ready) begin
        m_q = word; m_valid = 1; sb.push_back(word);
      end else begin
        lost = 1;
      end
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    if (lost)     m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  task automatic send(input logic [W-1:0] w, input bit dir, input bit rdy,
                      input bit rdy_last, input bit clr_last);
    for (int k = 0; k < W; k++) begin
      bit b;
      b = dir ? w[k] : w[W-1-k];
      step(1, k == 0, dir, b, (k == W-1) ? rdy_last : rdy, (k == W-1) && clr_last);
    end
  endtask

  task automatic settle();
    @(posedge CP);
    #1;
  endtask

  task automatic drain();
    step(0, 0, 0, 0, 1, 1);
  endtask

  task automatic pulse_reset();
    @(negedge CP);
    #1;
    bus.EN = 0; bus.SOF = 0; bus.DIR = 0; bus.SDI = 0; bus.READY = 0; bus.CLR_OVR = 0;
    CR = 0;
    #1;
    model_reset();
    check("rst_q", bus.Q, 0);
    check("rst_valid", bus.VALID, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_ovr", bus.OVR, 0);
    #1;
    CR = 1;
  endtask

  // Monitor: detects each word load and checks it against the scoreboard, plus status flags.
  initial begin
    bit v_prev;
    logic [W-1:0] e;
    v_prev = 0;
    forever begin
      @(negedge CP);
      if (mon_en) begin
        // READY seen now is the value the last rising edge used.
        if (bus.VALID && (!v_prev || bus.READY)) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL word: got unexpected load %0h expected none at %0t", bus.Q, $time);
          end else begin
            e = sb.pop_front();
            check("word", bus.Q, e);
          end
        end
        check("valid", bus.VALID, m_valid);
        check("busy", bus.BUSY, m_active);
        check("ovr", bus.OVR, m_ovr);
        check("q_hold", bus.Q, m_q);
      end
      v_prev = bus.VALID;
    end
  end

  initial begin
    CR = 0;
    bus.EN = 0; bus.SOF = 0; bus.DIR = 0; bus.SDI = 0; bus.READY = 0; bus.CLR_OVR = 0;
    model_reset();
    #12;
    check("init_q", bus.Q, 0);
    check("init_valid", bus.VALID, 0);
    check("init_busy", bus.BUSY, 0);
    check("init_ovr", bus.OVR, 0);
    #1;
    CR = 1;
    mon_en = 1;

    // MSB-first 1,0,1,1
    send(4'b1011, DIR_MSB_FIRST, 0, 0, 0);
    settle();
    check("msb_q", bus.Q, 4'b1011);
    check("msb_valid", bus.VALID, 1);
    check("msb_busy", bus.BUSY, 0);
    drain();
    settle();
    check("msb_consumed", bus.VALID, 0);
    check("msb_q_kept", bus.Q, 4'b1011);

    // LSB-first 1,0,1,1 with DIR wiggling after SOF
    for (int k = 0; k < W; k++) begin
      bit bits[4];
      bits = '{1, 0, 1, 1};
      step(1, k == 0, (k == 0) ? 1'b1 : 1'($urandom), bits[k], 0, 0);
    end
    settle();
    check("lsb_q", bus.Q, 4'b1101);
    drain();

    // EN gaps with noise on SDI/SOF/DIR while EN=0
    for (int k = 0; k < W; k++) begin
      bit bits[4];
      bits = '{0, 1, 1, 0};
      if (k > 0)
        repeat ($urandom_range(1, 3)) step(0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
      step(1, k == 0, 0, bits[k], 0, 0);
    end
    settle();
    check("gap_q", bus.Q, 4'b0110);
    check("gap_valid", bus.VALID, 1);
    drain();

    // Overrun, then consume, then clear
    send(4'hA, 0, 0, 0, 0);
    send(4'h5, 0, 0, 0, 0);
    settle();
    check("ovr_q", bus.Q, 4'hA);
    check("ovr_valid", bus.VALID, 1);
    check("ovr_set", bus.OVR, 1);
    step(0, 0, 0, 0, 1, 0);
    settle();
    check("ovr_consumed", bus.VALID, 0);
    check("ovr_sticky", bus.OVR, 1);
    step(0, 0, 0, 0, 0, 1);
    settle();
    check("ovr_cleared", bus.OVR, 0);
    // Clear on the overflowing edge loses to the set
    send(4'hA, 0, 0, 0, 0);
    send(4'h5, 0, 0, 0, 1);
    settle();
    check("ovr_set_wins", bus.OVR, 1);
    drain();
    step(0, 0, 0, 0, 0, 1);

    // SOF restart discards the partial frame
    step(1, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    send(4'b0110, 0, 0, 0, 0);
    settle();
    check("restart_q", bus.Q, 4'b0110);
    check("restart_ovr", bus.OVR, 0);
    // Drain-and-fill on the completion edge
    send(4'b1001, 1, 0, 1, 0);
    settle();
    check("fill_q", bus.Q, 4'b1001);
    check("fill_valid", bus.VALID, 1);
    check("fill_ovr", bus.OVR, 0);
    drain();

    // Reset mid-frame, then a clean frame
    step(1, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    pulse_reset();
    send(4'b1100, 0, 0, 0, 0);
    settle();
    check("post_rst_q", bus.Q, 4'b1100);
    drain();

    // Random traffic
    repeat (400)
      step(($urandom % 4) != 0, ($urandom % 8) == 0, 1'($urandom), 1'($urandom),
           1'($urandom), ($urandom % 10) == 0);

    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    @(negedge CP);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel frame receiver: the receiving end of the team's bidirectional shift-register link. A sender shifts a word out one bit per enabled clock, either MSB-first (left shift) or LSB-first (right shift). This block reassembles the word from the framed serial stream, holds it in a one-entry output buffer with a valid/ready handshake, and flags words lost to back-pressure. It sits between a 4-bit shift-register transmitter and any parallel consumer.

## Interface
- WIDTH, 4, word length in bits; legal range 2..16.
- CP  in  1  clock; all state changes on the rising edge.
- CR  in  1  asynchronous, active-low clear; highest priority.
- EN  in  1  bit strobe; SDI and SOF are sampled only when EN=1.
- SOF  in  1  start of frame; marks the current SDI bit as bit 0 of a new frame (qualified by EN).
- DIR  in  1  bit order: 0 = MSB-first (sender shifting left), 1 = LSB-first (sender shifting right); sampled only with SOF.
- SDI  in  1  serial data.
- READY  in  1  consumer accepts Q when VALID=1.
- CLR_OVR  in  1  synchronous clear of OVR.
- Q  out  WIDTH  last completed word.
- VALID  out  1  Q holds an unconsumed word.
- BUSY  out  1  a frame is in progress (state RECV).
- OVR  out  1  sticky overrun flag.

## Operation
- FSM states:
  - IDLE: EN=1 and SOF=1 captures SDI as the first bit, latches DIR, sets cnt=1, goes to RECV. EN=1 with SOF=0 is ignored.
  - RECV: each EN=1 shifts SDI into the assembly register and increments cnt. When cnt reaches WIDTH, the word is complete and the FSM returns to IDLE.
- Bit order:
  - DIR=0: asm <= {asm[WIDTH-2:0], SDI}; the first bit lands in the MSB.
  - DIR=1: asm <= {SDI, asm[WIDTH-1:1]}; the first bit lands in the LSB.
- cnt is $clog2(WIDTH+1) bits wide and never wraps; its only transitions are reset to 0/1 or +1.
- SOF in RECV: the partial frame is silently discarded. The current bit starts a new frame with cnt=1 and DIR is re-latched. OVR is not affected.
- EN=0: FSM, cnt and the assembly register hold. SOF, SDI and DIR are ignored.
- Output buffer on word completion:
  - If VALID=0, or VALID=1 and READY=1 in the same cycle: Q <= completed word, VALID=1.
  - Otherwise the word is dropped, Q/VALID are unchanged and OVR <= 1.
- Handshake: VALID=1 and READY=1 with no completion that cycle gives VALID <= 0. Q keeps its value after it is consumed.
- OVR: set has priority over CLR_OVR when both occur in the same cycle.
- Reset (CR=0, asynchronous, any time including mid-frame): Q=0, VALID=0, BUSY=0, OVR=0, state IDLE, cnt=0, assembly register 0.

## Timing
- BUSY rises on the edge that samples SOF. For WIDTH=1 it does not rise (WIDTH=1 is illegal).
- Latency: Q/VALID update on the same edge that samples the final bit; they are visible one cycle after that bit is presented. BUSY falls on that same edge.
- Back-to-back frames are supported: the SOF of the next frame may arrive on the cycle immediately after the last bit. Throughput is one word per WIDTH enabled cycles.
- Q and VALID are registered; there is no combinational path from inputs to outputs.
- Release of CR takes effect at the first CP edge after deassertion. No recovery handling is done inside the block.

## Structure
- Shared package serial_link_pkg holds:
  - state enum {IDLE, RECV};
  - DIR constants DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1, which the transmitter reuses.
- Sub-module sipo_shift_stage: WIDTH-bit assembly register with EN, DIR and load-first-bit control.
- The top level contains the FSM, counter, output buffer and OVR.

## Test plan
- Reset mid-frame: after 2 bits of a frame, pulse CR=0 between edges -> Q=0, VALID=0, BUSY=0, OVR=0 immediately. A following frame SOF with 1,1,0,0 (DIR=0) -> Q=4'b1100.
- DIR=0: EN=1 with SDI 1,0,1,1 and SOF on the first bit -> Q=4'b1011 and VALID=1 after the 4th edge. BUSY high for exactly 3 cycles of visibility.
- DIR=1: same bits 1,0,1,1 -> Q=4'b1101. Also run DIR=1 at SOF with DIR toggled mid-frame -> the result is unchanged.
- EN gaps: bits 0,1,1,0 (DIR=0) with EN=0 cycles inserted between each bit, SDI randomised while EN=0 -> Q=4'b0110, completing on the 4th enabled edge.
- Overrun: READY=0, frames 4'hA then 4'h5 back-to-back -> Q=4'hA, VALID=1, OVR=1. Then READY=1 for one cycle -> VALID=0. Then CLR_OVR=1 -> OVR=0. Repeat with CLR_OVR asserted on the overflow edge -> OVR=1.
- SOF restart: send 1,1 then SOF with 0,1,1,0 (DIR=0) -> exactly one word, Q=4'b0110, OVR=0. Also drain-and-fill in the same cycle: VALID=1, READY=1 on the completion edge -> new Q loaded, VALID stays 1, OVR=0.
